// File: rtl/w1_stream_reader_if.sv
// Weight-word stream from the conv1 weight-ROM reader to the conv1 engine.
// The ready/valid handshake is o_valid & o_ready.
interface w1_stream_reader_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 48
);
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_idx;
  logic          o_last;

  modport master (output o_valid, o_data, o_idx, o_last, input o_ready);
  modport slave  (input o_valid, o_data, o_idx, o_last, output o_ready);
endinterface

// File: rtl/w1_stream_reader.sv
// Read sequencer for the conv1 weight ROM: walks addresses 0..DEPTH-1, hides the
// registered ROM latency and streams tagged words through a 3-entry credit-checked FIFO.
module w1_stream_reader #(
  parameter int unsigned DEPTH = 25,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [AW-1:0]      w1_raddr,
  input  logic [DW-1:0]      w1_rdata,
  output logic               busy,
  output logic               done,
  w1_stream_reader_if.master o_stream
);
  localparam int unsigned NENT = 3;
  localparam int unsigned CW   = 3;
  localparam int unsigned NW   = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [NW-1:0]   r_na;
  logic [AW-1:0]   r_raddr;
  logic            r_s1_vld;
  logic            r_s2_vld;
  logic [AW-1:0]   r_s1_idx;
  logic [AW-1:0]   r_s2_idx;
  logic [NENT-1:0] r_vld;
  logic [NENT-1:0] r_last;
  logic [DW-1:0]   r_data [NENT];
  logic [AW-1:0]   r_idx  [NENT];

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_push_last;
  logic [CW-1:0]   w_occ;
  logic [CW-1:0]   w_infl;
  logic [CW-1:0]   w_wp;
  logic [AW-1:0]   w_addr;
  logic [NENT-1:0] w_vld_n;
  logic [NENT-1:0] w_last_n;
  logic [DW-1:0]   w_data_n [NENT];
  logic [AW-1:0]   w_idx_n  [NENT];

  assign w_pop       = r_vld[0] & o_stream.o_ready;
  assign w_push      = r_s2_vld;
  assign w_occ       = CW'(r_vld[0]) + CW'(r_vld[1]) + CW'(r_vld[2]);
  assign w_infl      = CW'(r_s1_vld) + CW'(r_s2_vld);
  assign w_wp        = w_occ - CW'(w_pop);
  assign w_addr      = (r_state == S_IDLE) ? '0 : r_na[AW-1:0];
  assign w_push_last = (r_s2_idx == AW'(DEPTH - 1));

  // Address 0 goes out on the start edge; later reads need a free slot counting this cycle's pop.
  assign w_issue = ((r_state == S_IDLE) && start) ||
                   ((r_state == S_RUN) && (r_na < NW'(DEPTH)) &&
                    ((w_occ + w_infl - CW'(w_pop)) < CW'(NENT)));

  // Sequencer FSM, address counter and issue-tag pipeline aligned to the ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_na     <= '0;
      r_raddr  <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s1_idx <= '0;
      r_s2_idx <= '0;
    end else begin
      r_done   <= 1'b0;
      r_s1_vld <= w_issue;
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      if (w_issue) begin
        r_raddr  <= w_addr;
        r_s1_idx <= w_addr;
        r_na     <= NW'(w_addr) + NW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_pop && r_last[0]) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shift-register FIFO: entry 0 is the head, and empty entries are kept all-zero.
  always_comb begin
    w_vld_n  = r_vld;
    w_last_n = r_last;
    for (int unsigned i = 0; i < NENT; i++) begin
      w_data_n[i] = r_data[i];
      w_idx_n[i]  = r_idx[i];
    end
    if (w_pop) begin
      for (int unsigned i = 0; i < NENT - 1; i++) begin
        w_vld_n[i]  = r_vld[i+1];
        w_last_n[i] = r_last[i+1];
        w_data_n[i] = r_data[i+1];
        w_idx_n[i]  = r_idx[i+1];
      end
      w_vld_n[NENT-1]  = 1'b0;
      w_last_n[NENT-1] = 1'b0;
      w_data_n[NENT-1] = '0;
      w_idx_n[NENT-1]  = '0;
    end
    if (w_push) begin
      for (int unsigned i = 0; i < NENT; i++) begin
        if (w_wp == CW'(i)) begin
          w_vld_n[i]  = 1'b1;
          w_last_n[i] = w_push_last;
          w_data_n[i] = w1_rdata;
          w_idx_n[i]  = r_s2_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_last <= '0;
      for (int unsigned i = 0; i < NENT; i++) begin
        r_data[i] <= '0;
        r_idx[i]  <= '0;
      end
    end else begin
      r_vld  <= w_vld_n;
      r_last <= w_last_n;
      for (int unsigned i = 0; i < NENT; i++) begin
        r_data[i] <= w_data_n[i];
        r_idx[i]  <= w_idx_n[i];
      end
    end
  end

  assign w1_raddr         = r_raddr;
  assign busy             = r_busy;
  assign done             = r_done;
  assign o_stream.o_valid = r_vld[0];
  assign o_stream.o_data  = r_data[0];
  assign o_stream.o_idx   = r_idx[0];
  assign o_stream.o_last  = r_last[0];
endmodule

// File: tb/tb_w1_stream_reader.sv
// Directed bench for w1_stream_reader with a registered ROM model.
// Each scenario task checks cycle-exact expectations against hand-derived timelines.
module tb_w1_stream_reader;
  localparam int unsigned DEPTH = 25;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 48;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] w1_raddr;
  logic [DW-1:0] w1_rdata;
  logic          busy;
  logic          done;
  int            n_cmp = 0;
  int            n_err = 0;

  w1_stream_reader_if #(.AW(AW), .DW(DW)) strm ();

  w1_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .w1_raddr (w1_raddr),
    .w1_rdata (w1_rdata),
    .busy     (busy),
    .done     (done),
    .o_stream (strm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w1_rdata <= {24'hA5A5A5, 19'd0, w1_raddr};

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {24'hA5A5A5, 19'd0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Credit invariant: buffered plus in-flight words never exceed the buffer depth.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (int'(dut.w_occ) + int'(dut.w_infl) > 3) begin
        n_err++;
        $display("FAIL credit_invariant: occ+inflight=%0d, required <= 3",
                 int'(dut.w_occ) + int'(dut.w_infl));
      end
    end
  end

  task automatic test_reset();
    strm.o_ready = 1'b0;
    start        = 1'b0;
    rst_n        = 1'b0;
    #1;
    n_cmp++;
    if ({w1_raddr, strm.o_valid, strm.o_idx, strm.o_last, strm.o_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: raddr=%0d valid=%b idx=%0d last=%b data=%h busy=%b done=%b, required all zero",
               w1_raddr, strm.o_valid, strm.o_idx, strm.o_last, strm.o_data, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({w1_raddr, strm.o_valid, strm.o_idx, strm.o_last, strm.o_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset: raddr=%0d valid=%b busy=%b done=%b, required all zero",
               w1_raddr, strm.o_valid, busy, done);
    end
  endtask

  task automatic test_free_run();
    int   exp_addr;
    logic exp_vld;
    strm.o_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      exp_addr = (c < 24) ? c : 24;
      exp_vld  = (c >= 2) && (c <= 26);
      n_cmp++;
      if (w1_raddr !== AW'(exp_addr)) begin
        n_err++;
        $display("FAIL free_raddr c=%0d: got %0d, want %0d", c, w1_raddr, exp_addr);
      end
      n_cmp++;
      if (strm.o_valid !== exp_vld) begin
        n_err++;
        $display("FAIL free_valid c=%0d: got %b, want %b", c, strm.o_valid, exp_vld);
      end
      if (exp_vld) begin
        n_cmp++;
        if (strm.o_idx !== AW'(c - 2) || strm.o_data !== rom_word(AW'(c - 2))) begin
          n_err++;
          $display("FAIL free_beat c=%0d: got idx %0d data %h, want idx %0d data %h",
                   c, strm.o_idx, strm.o_data, c - 2, rom_word(AW'(c - 2)));
        end
      end
      n_cmp++;
      if (strm.o_last !== (c == 26)) begin
        n_err++;
        $display("FAIL free_last c=%0d: got %b, want %b", c, strm.o_last, c == 26);
      end
      n_cmp++;
      if (done !== (c == 27)) begin
        n_err++;
        $display("FAIL free_done c=%0d: got %b, want %b", c, done, c == 27);
      end
      n_cmp++;
      if (busy !== (c <= 27)) begin
        n_err++;
        $display("FAIL free_busy c=%0d: got %b, want %b", c, busy, c <= 27);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int   exp_addr;
    int   exp_idx;
    logic exp_vld;
    strm.o_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (c <= 2)       exp_addr = c;
      else if (c <= 12) exp_addr = 2;
      else              exp_addr = (c - 10 < 24) ? c - 10 : 24;
      exp_vld = (c >= 2) && (c <= 36);
      exp_idx = (c <= 12) ? 0 : c - 12;
      n_cmp++;
      if (w1_raddr !== AW'(exp_addr)) begin
        n_err++;
        $display("FAIL stall_raddr c=%0d: got %0d, want %0d", c, w1_raddr, exp_addr);
      end
      n_cmp++;
      if (strm.o_valid !== exp_vld) begin
        n_err++;
        $display("FAIL stall_valid c=%0d: got %b, want %b", c, strm.o_valid, exp_vld);
      end
      if (exp_vld) begin
        n_cmp++;
        if (strm.o_idx !== AW'(exp_idx) || strm.o_data !== rom_word(AW'(exp_idx))) begin
          n_err++;
          $display("FAIL stall_beat c=%0d: got idx %0d data %h, want idx %0d",
                   c, strm.o_idx, strm.o_data, exp_idx);
        end
      end
      if (c >= 4 && c <= 12) begin
        n_cmp++;
        if (dut.w_occ !== 3'd3) begin
          n_err++;
          $display("FAIL stall_occ c=%0d: got %0d, want 3", c, dut.w_occ);
        end
      end
      n_cmp++;
      if (strm.o_last !== (c == 36) || done !== (c == 37) || busy !== (c <= 37)) begin
        n_err++;
        $display("FAIL stall_ctrl c=%0d: got last %b done %b busy %b, want %b %b %b",
                 c, strm.o_last, done, busy, c == 36, c == 37, c <= 37);
      end
      if (c == 2)  strm.o_ready = 1'b0;
      if (c == 12) strm.o_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_random_b2b();
    int beats;
    int ndone;
    int cyc;
    for (int s = 0; s < 5; s++) begin
      beats = 0;
      ndone = 0;
      cyc   = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (busy && cyc < 400) begin
        if (done) ndone++;
        strm.o_ready = 1'($urandom_range(0, 1));
        if (strm.o_valid && strm.o_ready) begin
          n_cmp++;
          if (strm.o_idx !== AW'(beats) || strm.o_data !== rom_word(AW'(beats)) ||
              strm.o_last !== (beats == 24)) begin
            n_err++;
            $display("FAIL rand_beat seq=%0d n=%0d: got idx %0d data %h last %b, want idx %0d last %b",
                     s, beats, strm.o_idx, strm.o_data, strm.o_last, beats, beats == 24);
          end
          beats++;
        end
        tick();
        cyc++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL rand_timeout seq=%0d: busy still %b after %0d cycles, want 0", s, busy, cyc);
      end
      n_cmp++;
      if (beats != 25) begin
        n_err++;
        $display("FAIL rand_count seq=%0d: got %0d beats, want 25", s, beats);
      end
      n_cmp++;
      if (ndone != 1) begin
        n_err++;
        $display("FAIL rand_done seq=%0d: got %0d done pulses, want 1", s, ndone);
      end
    end
    strm.o_ready = 1'b1;
  endtask

  task automatic test_start_held();
    int exp_addr;
    int cyc;
    strm.o_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int c = 0; c <= 31; c++) begin
      if (c <= 24)      exp_addr = c;
      else if (c <= 28) exp_addr = 24;
      else              exp_addr = c - 29;
      n_cmp++;
      if (w1_raddr !== AW'(exp_addr)) begin
        n_err++;
        $display("FAIL held_raddr c=%0d: got %0d, want %0d", c, w1_raddr, exp_addr);
      end
      n_cmp++;
      if (busy !== (c != 28) || done !== (c == 27)) begin
        n_err++;
        $display("FAIL held_ctrl c=%0d: got busy %b done %b, want %b %b",
                 c, busy, done, c != 28, c == 27);
      end
      if (c == 31) begin
        n_cmp++;
        if (strm.o_valid !== 1'b1 || strm.o_idx !== 5'd0) begin
          n_err++;
          $display("FAIL held_restart: got valid %b idx %0d, want 1 0", strm.o_valid, strm.o_idx);
        end
      end
      if (c < 31) tick();
    end
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_drain: busy %b after %0d cycles, want 0", busy, cyc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    strm.o_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    n_cmp++;
    if (strm.o_valid !== 1'b1 || strm.o_idx !== 5'd11) begin
      n_err++;
      $display("FAIL mid_pre: got valid %b idx %0d, want 1 11", strm.o_valid, strm.o_idx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({w1_raddr, strm.o_valid, strm.o_idx, strm.o_last, strm.o_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL mid_async_reset: raddr=%0d valid=%b idx=%0d busy=%b done=%b, required all zero",
               w1_raddr, strm.o_valid, strm.o_idx, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({w1_raddr, strm.o_valid, busy, done} !== '0) begin
      n_err++;
      $display("FAIL mid_post_reset: raddr=%0d valid=%b busy=%b done=%b, required all zero",
               w1_raddr, strm.o_valid, busy, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (w1_raddr !== 5'd0 || busy !== 1'b1 || strm.o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_restart: got raddr %0d busy %b valid %b, want 0 1 0",
               w1_raddr, busy, strm.o_valid);
    end
    tick();
    tick();
    n_cmp++;
    if (strm.o_valid !== 1'b1 || strm.o_idx !== 5'd0 || strm.o_data !== rom_word(5'd0)) begin
      n_err++;
      $display("FAIL mid_first_beat: got valid %b idx %0d data %h, want 1 0 %h",
               strm.o_valid, strm.o_idx, strm.o_data, rom_word(5'd0));
    end
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_drain: busy %b after %0d cycles, want 0", busy, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_random_b2b();
    test_start_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/w1_stream_reader.md
# w1_stream_reader

Read-side sequencer for the conv-layer-1 weight ROM. On `start`, it walks ROM addresses 0..DEPTH-1 and absorbs the ROM's one-cycle registered read latency. It presents each 48-bit word (6 output channels × 8-bit weight for one kernel tap) to the conv1 engine over a valid/ready stream, with tap index and last flag. A 3-entry output buffer with credit-based address issue sustains one word per cycle and never drops data under backpressure.

## Interface
- DEPTH, 25, number of ROM words per sequence (5×5 kernel taps)
- AW, 5, ROM address width
- DW, 48, ROM data width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sequence; sampled only when `busy`=0
- w1_raddr  out  AW  ROM read address, registered
- w1_rdata  in  DW  ROM data; valid one cycle after `w1_raddr` changes (registered ROM output)
- o_valid  out  1  output word available
- o_ready  in  1  consumer accepts word; handshake = `o_valid & o_ready`
- o_data  out  DW  weight word, FIFO head
- o_idx  out  AW  tap index of `o_data` (0..DEPTH-1)
- o_last  out  1  high with the word where `o_idx`=DEPTH-1
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after the last handshake

## Operation
- States: IDLE, RUN, FINISH.
- IDLE → RUN on `start`=1. Next-address counter `na` is cleared to 0.
- A read is issued in any RUN cycle where `na` < DEPTH and occ + inflight − pop < 3.
  - occ = FIFO occupancy (0..3).
  - inflight = issued reads not yet written to FIFO (0..2).
  - pop = handshake this cycle.
- Issuing a read means: `w1_raddr` ← `na` at the edge, `na` ← `na`+1.
- Read pipeline:
  - S1 (address registered): the edge at which `w1_raddr` is loaded.
  - S2: `w1_rdata` is valid for that address between the next edge and the one after.
  - The word is written to the FIFO, tagged with its index, at the second edge after issue.
  - An issue tag travels down S1/S2 so that only real issues are written.
- FIFO: 3 entries, in-order. Push and pop in the same cycle are allowed at any occupancy, including full with pop.
- `o_valid` = occ≠0. `o_data`/`o_idx` come from the head entry. `o_last` = (`o_idx`=DEPTH-1) & `o_valid`.
- RUN → FINISH on the handshake of the last word. FINISH lasts one cycle with `done`=1, then → IDLE.
- `busy` = 1 in RUN and FINISH.
- `start` while `busy`=1 is ignored. `start` in the FINISH cycle is also ignored, so a restart is accepted one cycle after `done`.
- `w1_raddr` holds its last value when no read is issued, and holds after the sequence ends.
- Overflow is impossible by construction. Verification must assert occ + inflight ≤ 3 at every edge.

## Timing
- Reset values: `w1_raddr`=0, `o_valid`=0, `o_idx`=0, `o_last`=0, `o_data`=0, `busy`=0, `done`=0. State=IDLE, FIFO empty, inflight=0.
- Reset is asynchronous. Asserting it mid-sequence aborts immediately: FIFO and pipeline tags are flushed, and no `done` is produced.
- Latency, with `start` sampled at edge E0:
  - `w1_raddr`=0 after E0.
  - `busy`=1 after E0.
  - `w1_rdata`(0) valid after E1.
  - `o_valid`=1 with `o_idx`=0 after E2.
- Throughput with `o_ready` held 1: addresses 0..24 issued on consecutive edges E0..E24. Handshakes occur on E3..E27, one per cycle.
- With `o_ready`=1 throughout:
  - `o_last` is visible between E26 and E27.
  - `done`=1 between E27 and E28.
  - `busy`=0 after E28.
- Under backpressure, issue stalls once occ + inflight reaches 3. When `o_ready` returns, the first handshake occurs in that same cycle and issue resumes in the same cycle (pop credit).

## Test plan
- ROM model: registered output, data = {24'hA5A5A5, 19'd0, addr}. Beats are checked against this.
- Free run: reset, `start` pulse, `o_ready`=1.
  - Addresses 0..24 on consecutive cycles.
  - `o_valid` 2 cycles after the start edge.
  - 25 consecutive beats, `o_idx` 0..24, data matches the model.
  - `o_last` only on idx 24.
  - `done` one cycle after beat 24, then `busy`=0.
- Stall: `o_ready`=0 for 10 cycles starting 3 cycles after `start`.
  - `w1_raddr` freezes at 2.
  - occ saturates at 3; occ + inflight ≤ 3 throughout.
  - On release: no lost or duplicated beats, full-rate resumption.
- Random `o_ready` (50%) over 5 back-to-back sequences:
  - Each sequence yields exactly 25 in-order beats with correct data.
  - Exactly one `done` per sequence.
- `start` held high continuously:
  - Second sequence starts only one cycle after `done`.
  - `start` pulses during RUN and FINISH have no effect.
- Reset mid-run: assert `rst_n`=0 after beat 10, for 2 cycles.
  - All outputs return to reset values asynchronously.
  - Next `start` restarts from idx 0 with `w1_raddr`=0.
